tx_uart: RTL and testbench

//  Serial UART transmitter: takes bytes on a valid/ready write port and drives 8N1
//  (or 8E1) frames on the TX pin at a fixed baud.

---
 rtl/tx_uart.sv | 158 +++++++++++++++
 tb/tb_tx_uart.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_uart.sv
// Byte-wide UART transmitter with a one-entry holding register, 8N1 framing by default.
// Define PARITY_EN to append an even-parity bit (8E1).
module tx_uart #(
  parameter int unsigned TIMER_BITS      = 32,
  parameter int unsigned CLOCKS_PER_BAUD = 868
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_wr,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_idle,
  output logic       o_overrun,
  output logic       o_uart_tx
);

  localparam logic [TIMER_BITS-1:0] BaudReload = TIMER_BITS'(CLOCKS_PER_BAUD - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            hold_q, hold_d;
  logic                  ready_q, ready_d;
  logic [7:0]            shift_q, shift_d;
  logic [2:0]            idx_q, idx_d;
  logic [TIMER_BITS-1:0] baud_q, baud_d;
  logic                  tx_q, tx_d;
  logic                  overrun_q, overrun_d;
  logic                  idle_q, idle_d;

  logic                  baud_tick;
  logic                  load;
  logic [2:0]            idx_next;

  assign baud_tick = (baud_q == '0);
  assign idx_next  = idx_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    ready_d   = ready_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    tx_d      = tx_q;
    overrun_d = overrun_q;
    baud_d    = baud_tick ? BaudReload : baud_q - TIMER_BITS'(1);
    load      = 1'b0;

    // Write port only looks at the registered ready, so a write on the edge the holding
    // register is consumed is dropped rather than bypassed.
    if (i_wr) begin
      if (ready_q) begin
        hold_d  = i_data;
        ready_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        baud_d = BaudReload;
        if (!ready_q) load = 1'b1;
      end
      StStart: begin
        if (baud_tick) begin
          state_d = StData;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (baud_tick) begin
          if (idx_q == 3'd7) begin
`ifdef PARITY_EN
            state_d = StParity;
            tx_d    = ^shift_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_next;
            tx_d  = shift_q[idx_next];
          end
        end
      end
`ifdef PARITY_EN
      StParity: begin
        if (baud_tick) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        if (baud_tick) begin
          if (!ready_q) load    = 1'b1;
          else          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // Move the held byte into the shifter and start a frame immediately.
    if (load) begin
      shift_d = hold_q;
      ready_d = 1'b1;
      tx_d    = 1'b0;
      baud_d  = BaudReload;
      state_d = StStart;
    end

    idle_d = (state_d == StIdle) && ready_d;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      ready_q   <= 1'b1;
      shift_q   <= '0;
      idx_q     <= '0;
      baud_q    <= BaudReload;
      tx_q      <= 1'b1;
      overrun_q <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      ready_q   <= ready_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      baud_q    <= baud_d;
      tx_q      <= tx_d;
      overrun_q <= overrun_d;
      idle_q    <= idle_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_idle    = idle_q;
  assign o_overrun = overrun_q;
  assign o_uart_tx = tx_q;

endmodule

// File: tb/tb_tx_uart.sv
// Self-checking bench for tx_uart: a mid-bit sampling receiver records frames, and each
// test compares them with frames built from the byte value. Honours PARITY_EN.
`timescale 1ns/1ps
module tb_tx_uart;

  localparam int CPB = 4;
`ifdef PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk     = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_wr    = 1'b0;
  logic [7:0] i_data  = 8'h00;
  logic       o_ready, o_idle, o_overrun, o_uart_tx;

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;
  bit rx_en = 1'b1;
  logic [10:0] rx_bits[$];
  int          rx_start[$];

  tx_uart #(
    .TIMER_BITS     (8),
    .CLOCKS_PER_BAUD(CPB)
  ) dut (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_wr     (i_wr),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .o_idle   (o_idle),
    .o_overrun(o_overrun),
    .o_uart_tx(o_uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected line level for each bit time of a frame: start, data LSB first, [parity], stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    f    = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
`ifdef PARITY_EN
    f[9] = (ones % 2 == 1);
`endif
    return f;
  endfunction

  // Receiver: on a low line, sample every bit at its middle and record the frame.
  initial begin : rx_model
    logic [10:0] bits;
    int s;
    forever begin
      @(posedge clk); #1;
      if (rx_en && o_uart_tx === 1'b0) begin
        s    = cyc;
        bits = '1;
        repeat (CPB / 2) @(posedge clk);
        #1 bits[0] = o_uart_tx;
        for (int k = 1; k < NB; k++) begin
          repeat (CPB) @(posedge clk);
          #1 bits[k] = o_uart_tx;
        end
        rx_bits.push_back(bits);
        rx_start.push_back(s);
        repeat (CPB / 2 - 1) @(posedge clk);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [7:0] b, output int acc);
    i_wr   = 1'b1;
    i_data = b;
    @(posedge clk); #1;
    i_wr = 1'b0;
    acc  = cyc;
  endtask

  task automatic wait_idle(input int budget, output int when, output bit ok);
    ok   = 1'b0;
    when = -1;
    for (int i = 0; i < budget; i++) begin
      if (o_idle === 1'b1) begin
        ok   = 1'b1;
        when = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (o_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    i_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (o_uart_tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b want 1", o_uart_tx); end
    tests_run++; if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    tests_run++; if (o_idle !== 1'b1) begin tests_failed++; $display("FAIL reset_idle: got %b want 1", o_idle); end
    tests_run++; if (o_overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b want 0", o_overrun); end
    i_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (o_uart_tx !== 1'b1) begin tests_failed++; $display("FAIL post_reset_tx: got %b want 1", o_uart_tx); end
  endtask

  task automatic send_one(input string tag, input logic [7:0] b);
    int acc, when, n0;
    bit ok;
    logic [10:0] exp;
    exp = frame_bits(b);
    n0  = rx_bits.size();
    wr(b, acc);
    tests_run++; if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL %s_ready_low: got %b want 0", tag, o_ready); end
    tests_run++; if (o_idle !== 1'b0) begin tests_failed++; $display("FAIL %s_idle_low: got %b want 0", tag, o_idle); end
    tests_run++; if (o_uart_tx !== 1'b1) begin tests_failed++; $display("FAIL %s_line_at_accept: got %b want 1", tag, o_uart_tx); end
    wait_idle(FRAME + 20, when, ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL %s_idle_timeout: got %b want 1", tag, ok); end
    tests_run++; if (when !== acc + 1 + FRAME) begin tests_failed++; $display("FAIL %s_frame_len: idle at %0d want %0d", tag, when, acc + 1 + FRAME); end
    tests_run++;
    if (rx_bits.size() !== n0 + 1) begin
      tests_failed++; $display("FAIL %s_frame_count: got %0d want %0d", tag, rx_bits.size(), n0 + 1);
    end else begin
      tests_run++; if (rx_bits[n0] !== exp) begin tests_failed++; $display("FAIL %s_bits: got %b want %b", tag, rx_bits[n0], exp); end
      tests_run++; if (rx_start[n0] !== acc + 1) begin tests_failed++; $display("FAIL %s_start_time: got %0d want %0d", tag, rx_start[n0], acc + 1); end
    end
  endtask

  task automatic test_single;
    send_one("single_55", 8'h55);
    for (int t = 0; t < 3; t++) send_one("single_rand", 8'($urandom));
  endtask

  task automatic test_back_to_back;
    logic [7:0] b1, b2;
    logic [10:0] e1, e2;
    int acc1, acc2, when, n0;
    bit ok;
    for (int t = 0; t < 2; t++) begin
      b1 = (t == 0) ? 8'hA5 : 8'($urandom);
      b2 = (t == 0) ? 8'h3C : 8'($urandom);
      e1 = frame_bits(b1);
      e2 = frame_bits(b2);
      n0 = rx_bits.size();
      wr(b1, acc1);
      wait_ready(10, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_timeout: got %b want 1", ok); end
      wr(b2, acc2);
      tests_run++; if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_queued: ready %b want 0", o_ready); end
      wait_idle(2 * FRAME + 20, when, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL b2b_idle_timeout: got %b want 1", ok); end
      tests_run++; if (when - (acc1 + 1) !== 2 * FRAME) begin tests_failed++; $display("FAIL b2b_total_len: got %0d want %0d", when - (acc1 + 1), 2 * FRAME); end
      tests_run++; if (o_overrun !== 1'b0) begin tests_failed++; $display("FAIL b2b_overrun: got %b want 0", o_overrun); end
      tests_run++;
      if (rx_bits.size() !== n0 + 2) begin
        tests_failed++; $display("FAIL b2b_frame_count: got %0d want %0d", rx_bits.size(), n0 + 2);
      end else begin
        tests_run++; if (rx_bits[n0] !== e1) begin tests_failed++; $display("FAIL b2b_bits1: got %b want %b", rx_bits[n0], e1); end
        tests_run++; if (rx_bits[n0+1] !== e2) begin tests_failed++; $display("FAIL b2b_bits2: got %b want %b", rx_bits[n0+1], e2); end
        tests_run++; if (rx_start[n0+1] - rx_start[n0] !== FRAME) begin tests_failed++; $display("FAIL b2b_gap: got %0d want %0d", rx_start[n0+1] - rx_start[n0], FRAME); end
      end
    end
  endtask

  // Writes on three consecutive edges: the second lands on the edge that moves the first byte
  // out of the holding register (ready still low), so it is the one dropped.
  task automatic test_overrun;
    logic [7:0] b1, b2, b3;
    logic [10:0] e1, e3;
    int when, n0, acc;
    bit ok;
    b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    e1 = frame_bits(b1);
    e3 = frame_bits(b3);
    n0 = rx_bits.size();
    i_wr = 1'b1;
    i_data = b1; @(posedge clk); #1;
    i_data = b2; @(posedge clk); #1;
    i_data = b3; @(posedge clk); #1;
    i_wr = 1'b0;
    tests_run++; if (o_overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_set: got %b want 1", o_overrun); end
    wait_idle(2 * FRAME + 30, when, ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL ovr_idle_timeout: got %b want 1", ok); end
    tests_run++;
    if (rx_bits.size() !== n0 + 2) begin
      tests_failed++; $display("FAIL ovr_frame_count: got %0d want %0d", rx_bits.size(), n0 + 2);
    end else begin
      tests_run++; if (rx_bits[n0] !== e1) begin tests_failed++; $display("FAIL ovr_bits1: got %b want %b", rx_bits[n0], e1); end
      tests_run++; if (rx_bits[n0+1] !== e3) begin tests_failed++; $display("FAIL ovr_bits3: got %b want %b", rx_bits[n0+1], e3); end
    end
    send_one("ovr_after", 8'($urandom));
    tests_run++; if (o_overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_sticky: got %b want 1", o_overrun); end
    acc = 0;
  endtask

  task automatic test_reset_abort;
    logic [10:0] e;
    int acc, acc2, lows;
    bit ok;
    rx_en = 1'b0;
    e = frame_bits(8'hF0);
    wr(8'hF0, acc);
    wait_ready(10, ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL abort_ready_timeout: got %b want 1", ok); end
    wr(8'($urandom), acc2);
    while (cyc < acc + 1 + 4 * CPB + CPB / 2) begin
      @(posedge clk); #1;
    end
    tests_run++; if (o_uart_tx !== e[4]) begin tests_failed++; $display("FAIL abort_bit3: got %b want %b", o_uart_tx, e[4]); end
    tests_run++; if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL abort_queued: ready %b want 0", o_ready); end
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    tests_run++; if (o_uart_tx !== 1'b1) begin tests_failed++; $display("FAIL abort_tx: got %b want 1", o_uart_tx); end
    tests_run++; if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_ready: got %b want 1", o_ready); end
    tests_run++; if (o_idle !== 1'b1) begin tests_failed++; $display("FAIL abort_idle: got %b want 1", o_idle); end
    tests_run++; if (o_overrun !== 1'b0) begin tests_failed++; $display("FAIL abort_overrun_clr: got %b want 0", o_overrun); end
    lows = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(posedge clk); #1;
      if (o_uart_tx !== 1'b1 || o_idle !== 1'b1) lows++;
    end
    tests_run++; if (lows !== 0) begin tests_failed++; $display("FAIL abort_quiet: %0d active cycles want 0", lows); end
    rx_en = 1'b1;
  endtask

  task automatic test_parity;
    logic [7:0] bytes[3];
    logic [10:0] got;
    logic exp9;
    int n0;
    bytes[0] = 8'h07; bytes[1] = 8'h03; bytes[2] = 8'($urandom);
    for (int t = 0; t < 3; t++) begin
      n0 = rx_bits.size();
      send_one("parity", bytes[t]);
`ifdef PARITY_EN
      exp9 = ^bytes[t];
`else
      exp9 = 1'b1;
`endif
      if (rx_bits.size() > n0) begin
        got = rx_bits[n0];
        tests_run++; if (got[9] !== exp9) begin tests_failed++; $display("FAIL parity_bit: byte %h got %b want %b", bytes[t], got[9], exp9); end
      end
    end
  endtask

  task automatic test_loopback;
    logic [7:0] bytes[3];
    logic [10:0] got;
    int acc, when, n0;
    bit ok;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h5A;
    n0 = rx_bits.size();
    wr(bytes[0], acc);
    for (int t = 1; t < 3; t++) begin
      wait_ready(FRAME + 10, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL loop_ready_timeout: got %b want 1", ok); end
      wr(bytes[t], acc);
    end
    wait_idle(3 * FRAME + 20, when, ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL loop_idle_timeout: got %b want 1", ok); end
    tests_run++;
    if (rx_bits.size() !== n0 + 3) begin
      tests_failed++; $display("FAIL loop_frame_count: got %0d want %0d", rx_bits.size(), n0 + 3);
    end else begin
      for (int t = 0; t < 3; t++) begin
        got = rx_bits[n0+t];
        tests_run++; if (got[8:1] !== bytes[t]) begin tests_failed++; $display("FAIL loop_byte: got %h want %h", got[8:1], bytes[t]); end
        tests_run++; if (got[0] !== 1'b0) begin tests_failed++; $display("FAIL loop_start: got %b want 0", got[0]); end
        tests_run++; if (got[NB-1] !== 1'b1) begin tests_failed++; $display("FAIL loop_stop: got %b want 1", got[NB-1]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_abort();
    test_parity();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
